// File: rtl/mac_accum.sv
// Packet accumulator for the multiplier output stream: sums one in_last-terminated
// packet with saturation and presents sum, beat count and status on a valid/ready port.
module mac_accum #(
    parameter int IN_W      = 16,
    parameter int ACC_W     = 24,
    parameter int MAX_BEATS = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_trunc,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic [ACC_W-1:0] sum_reg, sum_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             oovf_reg, oovf_next;
    logic             trunc_reg, trunc_next;
    logic             valid_reg, valid_next;

    logic             in_idle;
    logic             accept;
    logic             at_max;
    logic             term;
    logic             sat;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic             ovf_upd;

    assign in_idle  = (state_reg == IDLE);
    assign in_ready = (state_reg != HOLD);
    assign accept   = in_valid && in_ready;

    // A packet starts from zero in IDLE, so no explicit clear of acc is needed on handshake.
    assign base     = in_idle ? '0 : acc_reg;
    assign sum_wide = {1'b0, base} + (ACC_W+1)'(in_data);
    assign sat      = sum_wide[ACC_W];

    // Carry out forces every bit high; an already saturated acc re-saturates on any non-zero beat.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_W; gi = gi + 1) begin : g_sat
            assign acc_upd[gi] = sum_wide[gi] | sat;
        end
    endgenerate

    assign cnt_upd = in_idle ? CNT_W'(1) : cnt_reg + 1'b1;
    assign ovf_upd = (in_idle ? 1'b0 : ovf_reg) | sat;
    assign at_max  = (cnt_upd == MAX_CNT);
    assign term    = accept && (in_last || at_max);

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        sum_next   = sum_reg;
        count_next = count_reg;
        oovf_next  = oovf_reg;
        trunc_next = trunc_reg;
        valid_next = valid_reg;

        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_next = acc_upd;
                    cnt_next = cnt_upd;
                    ovf_next = ovf_upd;
                    if (term) begin
                        state_next = HOLD;
                        sum_next   = acc_upd;
                        count_next = cnt_upd;
                        oovf_next  = ovf_upd;
                        trunc_next = at_max && !in_last;
                        valid_next = 1'b1;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            HOLD: begin
                // Result registers are left untouched so they read back after the handshake.
                if (out_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            sum_reg   <= '0;
            count_reg <= '0;
            oovf_reg  <= 1'b0;
            trunc_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
            sum_reg   <= sum_next;
            count_reg <= count_next;
            oovf_reg  <= oovf_next;
            trunc_reg <= trunc_next;
            valid_reg <= valid_next;
        end
    end

    assign out_sum   = sum_reg;
    assign out_count = count_reg;
    assign out_ovf   = oovf_reg;
    assign out_trunc = trunc_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_mac_accum.sv
// Randomized scoreboard bench for mac_accum; a narrow accumulator and short packet
// limit are used so saturation and forced termination occur often.
module tb_mac_accum;

    localparam int     IN_W      = 16;
    localparam int     ACC_W     = 18;
    localparam int     MAX_BEATS = 6;
    localparam int     CNT_W     = 3;
    localparam longint ACC_MAX   = (longint'(1) << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             out_trunc;
    logic             out_valid;
    logic             out_ready = 1'b0;

    mac_accum #(
        .IN_W     (IN_W),
        .ACC_W    (ACC_W),
        .MAX_BEATS(MAX_BEATS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_ovf  (out_ovf),
        .out_trunc(out_trunc),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint sum;
        int     count;
        bit     ovf;
        bit     trunc;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    longint pk_sum = 0;
    int     pk_n = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: a packet is the list of accepted beats up to in_last or MAX_BEATS;
    // its result is the true integer sum clipped to the accumulator range.
    task automatic model_beat(input logic [IN_W-1:0] d, input logic l);
        pk_sum += longint'(d);
        pk_n++;
        if (l || pk_n == MAX_BEATS) begin
            exp_t e;
            e.sum   = (pk_sum > ACC_MAX) ? ACC_MAX : pk_sum;
            e.count = pk_n;
            e.ovf   = (pk_sum > ACC_MAX);
            e.trunc = (pk_n == MAX_BEATS) && !l;
            e.cyc   = cyc + 1;
            q.push_back(e);
            $display("push: sum=0x%0h count=%0d ovf=%0d trunc=%0d due=%0d",
                     e.sum, e.count, e.ovf, e.trunc, e.cyc);
            pk_sum = 0;
            pk_n   = 0;
        end
    endtask

    task automatic step(input logic v, input logic [IN_W-1:0] d, input logic l,
                        input logic r, output bit acc);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        acc = v && in_ready && reset_n;
        if (acc) model_beat(d, l);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic l,
                        input int gap_pct, input int rdy_pct);
        bit acc;
        bit v;
        bit r;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc) begin
            v = ($urandom_range(0, 99) >= gap_pct);
            r = ($urandom_range(0, 99) < rdy_pct);
            step(v, d, l, r, acc);
            tries++;
            if (!acc && tries > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: beat 0x%0h not accepted within 200 cycles", d);
                break;
            end
        end
    endtask

    task automatic idle(input int n, input logic r);
        bit acc;
        repeat (n) step(1'b0, '0, 1'b0, r, acc);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_sum", longint'(out_sum), 0);
        check("rst_out_count", longint'(out_count), 0);
        check("rst_out_ovf", longint'(out_ovf), 0);
        check("rst_out_trunc", longint'(out_trunc), 0);
        #1 reset_n = 1'b1;
        pk_sum = 0;
        pk_n   = 0;
        q.delete();
        $display("reset pulse at cycle %0d", cyc);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per presented result and rechecks it while held.
    exp_t cur_exp;
    bit   prev_valid = 1'b0;
    bit   prev_hs = 1'b0;
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            check("in_ready", longint'(in_ready), longint'(!out_valid));
            if (out_valid) begin
                if (!prev_valid || prev_hs) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: got sum=0x%0h count=%0d, expected none (cycle %0d)",
                                 out_sum, out_count, cyc);
                    end else begin
                        cur_exp = q.pop_front();
                        check("latency", longint'(cyc), longint'(cur_exp.cyc));
                        $display("result: sum=0x%0h count=%0d ovf=%0d trunc=%0d cycle=%0d",
                                 out_sum, out_count, out_ovf, out_trunc, cyc);
                    end
                end
                check("out_sum", longint'(out_sum), cur_exp.sum);
                check("out_count", longint'(out_count), longint'(cur_exp.count));
                check("out_ovf", longint'(out_ovf), longint'(cur_exp.ovf));
                check("out_trunc", longint'(out_trunc), longint'(cur_exp.trunc));
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_result: got out_valid=0, expected sum=0x%0h count=%0d (cycle %0d)",
                         q[0].sum, q[0].count, cyc);
                void'(q.pop_front());
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end else begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end
    end

    initial begin
        bit acc;
        int len;
        bit big;
        logic [IN_W-1:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_sum", longint'(out_sum), 0);
        check("reset_out_count", longint'(out_count), 0);
        check("reset_out_ovf", longint'(out_ovf), 0);
        check("reset_out_trunc", longint'(out_trunc), 0);
        check("reset_in_ready", longint'(in_ready), 1);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat packet
        send(16'h0010, 1'b1, 0, 100);
        idle(2, 1'b1);

        // Three beats with a gap, then backpressure with a pending beat
        send(16'h0006, 1'b0, 0, 0);
        send(16'h0014, 1'b0, 0, 0);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        send(16'hFE01, 1'b1, 0, 0);
        repeat (5) step(1'b1, 16'h0033, 1'b1, 1'b0, acc);
        step(1'b1, 16'h0033, 1'b1, 1'b1, acc);
        send(16'h0033, 1'b1, 0, 100);
        idle(2, 1'b1);

        // Saturation, then a fresh packet clears ovf
        for (int i = 0; i < 5; i++) send(16'hFFFF, (i == 4), 0, 100);
        send(16'h0001, 1'b1, 0, 100);
        idle(2, 1'b1);

        // Forced termination at MAX_BEATS; the leftover beat is its own packet
        for (int i = 0; i < MAX_BEATS + 1; i++) send(16'h0002, (i == MAX_BEATS), 0, 100);
        idle(2, 1'b1);

        // Reset mid-packet, then reset while a result is held
        send(16'h0100, 1'b0, 0, 100);
        send(16'h0100, 1'b0, 0, 100);
        do_reset();
        send(16'h0005, 1'b1, 0, 100);
        idle(2, 1'b1);
        step(1'b1, 16'h0042, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        do_reset();
        idle(2, 1'b1);

        // Randomized packets with gaps, backpressure and occasional resets
        for (int p = 0; p < 400; p++) begin
            len = $urandom_range(1, MAX_BEATS + 2);
            big = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < len; b++) begin
                d = big ? IN_W'($urandom_range(16'hC000, 16'hFFFF)) : IN_W'($urandom_range(0, 16'h03FF));
                send(d, (b == len - 1), 25, 60);
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        idle(6, 1'b1);
        check("drain_queue", longint'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
